// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// Free-running raster timing generator with built-in test patterns.
// Counters advance on cen_i; every output is registered from the pre-edge counter position.
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cen_i,
    input  logic [1:0]  pat_sel_i,
    output logic [23:0] vid_rgb_o,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic [11:0] pix_x_o,
    output logic [11:0] pix_y_o,
    output logic        sof_o,
    output logic [7:0]  frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt_reg, v_cnt_reg;
    logic [11:0] h_cnt_next, v_cnt_next;
    logic [1:0]  pat_reg;
    logic [1:0]  pat_cur;
    logic [7:0]  frame_cur;
    logic        at_origin, hblank, vblank, de, hsync, vsync;
    logic [6:0]  bar_edge;
    logic [2:0]  bar_idx;
    logic [11:0] scroll_x;
    logic [23:0] pattern, rgb_next;

    always_comb begin
        at_origin  = (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
        h_cnt_next = (h_cnt_reg == H_LAST) ? 12'd0 : h_cnt_reg + 12'd1;
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            v_cnt_next = (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
        end
    end

    always_comb begin
        hblank = (h_cnt_reg >= H_ACT);
        vblank = (v_cnt_reg >= V_ACT);
        de     = ~hblank & ~vblank;
        hsync  = (h_cnt_reg >= HS_START && h_cnt_reg < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync  = (v_cnt_reg >= VS_START && v_cnt_reg < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    // Pixel (0,0) already shows the new frame's pattern and frame count, so the
    // pattern always uses the values presented alongside that pixel.
    always_comb begin
        pat_cur   = at_origin ? pat_sel_i : pat_reg;
        frame_cur = at_origin ? frame_cnt_o + 8'd1 : frame_cnt_o;
        scroll_x  = h_cnt_reg + {4'b0000, frame_cur};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_bar
            assign bar_edge[gi] = (h_cnt_reg >= 12'((gi + 1) * BAR_W));
        end
    endgenerate

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + {2'b00, bar_edge[i]};
        end
    end

    // Bar colours follow the inverted index bits: R=~idx[1], G=~idx[2], B=~idx[0].
    always_comb begin
        pattern = 24'h000000;
        case (pat_cur)
            2'd0:    pattern = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd1:    pattern = {3{h_cnt_reg[10:3]}};
            2'd2:    pattern = 24'hFF5A43;
            default: pattern = {24{scroll_x[5] ^ v_cnt_reg[5]}};
        endcase
        rgb_next = de ? pattern : 24'h000000;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_reg   <= 12'd0;
            v_cnt_reg   <= 12'd0;
            pat_reg     <= 2'd0;
            frame_cnt_o <= 8'd0;
            vid_rgb_o   <= 24'h000000;
            vh_blank_o  <= 2'b11;
            dvh_sync_o  <= {1'b0, ~SYNC_POL, ~SYNC_POL};
            pix_x_o     <= 12'd0;
            pix_y_o     <= 12'd0;
            sof_o       <= 1'b0;
        end else if (cen_i) begin
            h_cnt_reg  <= h_cnt_next;
            v_cnt_reg  <= v_cnt_next;
            if (at_origin) begin
                pat_reg     <= pat_sel_i;
                frame_cnt_o <= frame_cur;
            end
            vid_rgb_o  <= rgb_next;
            vh_blank_o <= {vblank, hblank};
            dvh_sync_o <= {de, vsync, hsync};
            pix_x_o    <= h_cnt_reg;
            pix_y_o    <= v_cnt_reg;
            sof_o      <= at_origin;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Scoreboarded bench for video_timing_gen using a reduced raster so whole frames fit in a short run.
module tb_video_timing_gen;

    localparam int HA = 64, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
    localparam int VA = 40, VFP = 2, VS = 3, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int BAR_W = HA / 8;
    localparam int SFRAME = (8 + 2 + 2 + 2) * (4 + 1 + 1 + 1);

    typedef struct packed {
        logic [23:0] rgb;
        logic [1:0]  blank;
        logic [2:0]  sync;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic [7:0]  fc;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b0, cen_i = 1'b0;
    logic [1:0]  pat_sel_i = 2'd0;
    logic [23:0] vid_rgb_o;
    logic [1:0]  vh_blank_o;
    logic [2:0]  dvh_sync_o;
    logic [11:0] pix_x_o, pix_y_o;
    logic        sof_o;
    logic [7:0]  frame_cnt_o;

    logic        s_rst = 1'b0, s_cen = 1'b0;
    logic [1:0]  s_pat = 2'd0;
    logic [23:0] s_rgb;
    logic [1:0]  s_blank;
    logic [2:0]  s_sync;
    logic [11:0] s_x, s_y;
    logic        s_sof;
    logic [7:0]  s_fc;

    video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                       .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .cen_i(cen_i), .pat_sel_i(pat_sel_i),
        .vid_rgb_o(vid_rgb_o), .vh_blank_o(vh_blank_o), .dvh_sync_o(dvh_sync_o),
        .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .sof_o(sof_o), .frame_cnt_o(frame_cnt_o)
    );

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) dut_small (
        .clk_i(clk), .rst_i(s_rst), .cen_i(s_cen), .pat_sel_i(s_pat),
        .vid_rgb_o(s_rgb), .vh_blank_o(s_blank), .dvh_sync_o(s_sync),
        .pix_x_o(s_x), .pix_y_o(s_y), .sof_o(s_sof), .frame_cnt_o(s_fc)
    );

    out_t got;
    assign got = {vid_rgb_o, vh_blank_o, dvh_sync_o, pix_x_o, pix_y_o, sof_o, frame_cnt_o};

    int   vectors = 0;
    int   errors  = 0;
    out_t sb[$];
    out_t exp_o;
    int   m_h = 0, m_v = 0, m_fc = 0, m_pat = 0;
    int   en_cnt = 0, last_sof = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Drive one clock; on an enabled cycle push the model's expected output and advance the model.
    task automatic tick(input bit en);
        out_t e;
        int fc_o, pat;
        bit at0, hb, vb, de, hs, vs;
        logic [7:0] g8;
        logic [23:0] rgb;
        cen_i = en;
        if (rst_i) begin
            m_h = 0; m_v = 0; m_fc = 0; m_pat = 0;
        end else if (en) begin
            at0  = (m_h == 0) && (m_v == 0);
            fc_o = at0 ? (m_fc + 1) % 256 : m_fc;
            pat  = at0 ? int'(pat_sel_i) : m_pat;
            hb   = (m_h >= HA);
            vb   = (m_v >= VA);
            de   = !hb && !vb;
            hs   = (m_h >= HA + HFP) && (m_h < HA + HFP + HS);
            vs   = (m_v >= VA + VFP) && (m_v < VA + VFP + VS);
            g8   = 8'(m_h / 8);
            case (pat)
                0:       rgb = bars[(m_h / BAR_W) % 8];
                1:       rgb = {g8, g8, g8};
                2:       rgb = 24'hFF5A43;
                default: rgb = ((((m_h + fc_o) / 32) % 2) != ((m_v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            endcase
            e.rgb   = de ? rgb : 24'h000000;
            e.blank = {vb, hb};
            e.sync  = {de, vs, hs};
            e.x     = 12'(m_h);
            e.y     = 12'(m_v);
            e.sof   = at0;
            e.fc    = 8'(fc_o);
            sb.push_back(e);
            if (at0) begin
                m_fc  = fc_o;
                m_pat = pat;
            end
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
            en_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; pat_sel_i = 2'd0;
        repeat (3) tick(1'b1);
        vectors++; if (vid_rgb_o !== 24'h0)   begin errors++; $display("FAIL rst_rgb: got %h required 000000", vid_rgb_o); end
        vectors++; if (vh_blank_o !== 2'b11)  begin errors++; $display("FAIL rst_blank: got %b required 11", vh_blank_o); end
        vectors++; if (dvh_sync_o !== 3'b000) begin errors++; $display("FAIL rst_sync: got %b required 000", dvh_sync_o); end
        vectors++; if (pix_x_o !== 12'd0 || pix_y_o !== 12'd0) begin errors++; $display("FAIL rst_pix: got (%0d,%0d) required (0,0)", pix_x_o, pix_y_o); end
        vectors++; if (sof_o !== 1'b0)        begin errors++; $display("FAIL rst_sof: got %b required 0", sof_o); end
        vectors++; if (frame_cnt_o !== 8'd0)  begin errors++; $display("FAIL rst_fc: got %0d required 0", frame_cnt_o); end
        rst_i = 1'b0;
        tick(1'b1);
        if (sb.size() == 0) begin vectors++; errors++; $display("FAIL sb_empty: got no entry required one"); end
        else begin exp_o = sb.pop_front(); vectors++; if (got !== exp_o) begin errors++; $display("FAIL first_pixel: got %h required %h", got, exp_o); end end
        vectors++; if (sof_o !== 1'b1 || frame_cnt_o !== 8'd1) begin errors++; $display("FAIL first_sof: got sof=%b fc=%0d required sof=1 fc=1", sof_o, frame_cnt_o); end
        vectors++; if (vh_blank_o !== 2'b00 || dvh_sync_o[2] !== 1'b1) begin errors++; $display("FAIL first_de: got blank=%b sync=%b required blank=00 de=1", vh_blank_o, dvh_sync_o); end
        last_sof = en_cnt;
    endtask

    task automatic test_line_timing();
        bit started = 0, prev_vb = 0;
        int de_n = 0, hs_n = 0, vs_lines = 0;
        pat_sel_i = 2'd0;
        for (int i = 0; i < FRAME + HT; i++) begin
            tick(1'b1);
            if (sb.size() == 0) begin vectors++; errors++; $display("FAIL sb_empty: got no entry required one"); continue; end
            exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin errors++; $display("FAIL line_pixel: got %h required %h", got, exp_o); end
            if (exp_o.x == 0) begin started = 1; de_n = 0; hs_n = 0; end
            de_n += int'(dvh_sync_o[2]);
            hs_n += int'(dvh_sync_o[0]);
            if (exp_o.x == 0 && dvh_sync_o[1]) vs_lines++;
            if (started && exp_o.x == HT - 1) begin
                vectors++; if (de_n != ((exp_o.y < VA) ? HA : 0)) begin errors++; $display("FAIL de_per_line y=%0d: got %0d required %0d", exp_o.y, de_n, (exp_o.y < VA) ? HA : 0); end
                vectors++; if (hs_n != HS) begin errors++; $display("FAIL hsync_width y=%0d: got %0d required %0d", exp_o.y, hs_n, HS); end
            end
            if (vh_blank_o[1] && !prev_vb) begin
                vectors++; if (pix_y_o !== 12'(VA)) begin errors++; $display("FAIL vblank_rise: got y=%0d required %0d", pix_y_o, VA); end
            end
            prev_vb = vh_blank_o[1];
            if (sof_o) begin
                vectors++; if (en_cnt - last_sof != FRAME) begin errors++; $display("FAIL sof_period: got %0d required %0d", en_cnt - last_sof, FRAME); end
                last_sof = en_cnt;
            end
            if (exp_o.y == 0 && exp_o.x == BAR_W) begin
                vectors++; if (vid_rgb_o !== 24'hFFFF00) begin errors++; $display("FAIL bar1: got %h required FFFF00", vid_rgb_o); end
            end
            if (exp_o.y == 0 && exp_o.x == HA - 1) begin
                vectors++; if (vid_rgb_o !== 24'h000000) begin errors++; $display("FAIL bar7: got %h required 000000", vid_rgb_o); end
            end
        end
        vectors++; if (vs_lines != VS) begin errors++; $display("FAIL vsync_lines: got %0d required %0d", vs_lines, VS); end
    endtask

    task automatic test_pattern_switch();
        bit switched = 0, hit_new = 0, hit_blank = 0;
        for (int i = 0; i < 2 * FRAME && !hit_blank; i++) begin
            if (m_h == 20 && m_v == 30) begin pat_sel_i = 2'd2; switched = 1; end
            tick(1'b1);
            if (sb.size() == 0) begin vectors++; errors++; $display("FAIL sb_empty: got no entry required one"); continue; end
            exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin errors++; $display("FAIL switch_pixel: got %h required %h", got, exp_o); end
            if (switched && !hit_new && exp_o.y == 30 && exp_o.x == 21) begin
                vectors++; if (vid_rgb_o !== 24'h00FFFF) begin errors++; $display("FAIL still_bars: got %h required 00FFFF", vid_rgb_o); end
            end
            if (switched && exp_o.x == 0 && exp_o.y == 0) begin
                hit_new = 1;
                vectors++; if (vid_rgb_o !== 24'hFF5A43) begin errors++; $display("FAIL new_pattern: got %h required FF5A43", vid_rgb_o); end
            end
            if (hit_new && exp_o.y == 0 && exp_o.x == HA) begin
                hit_blank = 1;
                vectors++; if (vid_rgb_o !== 24'h000000) begin errors++; $display("FAIL blank_black: got %h required 000000", vid_rgb_o); end
            end
        end
        vectors++; if (!hit_blank) begin errors++; $display("FAIL switch_timeout: got no new frame required one within %0d cycles", 2 * FRAME); end
    endtask

    task automatic test_cen();
        out_t held;
        bit en;
        held = got;
        pat_sel_i = 2'd1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            en = (i % 3 == 0);
            tick(en);
            if (en) begin
                if (sb.size() == 0) begin vectors++; errors++; $display("FAIL sb_empty: got no entry required one"); continue; end
                exp_o = sb.pop_front(); vectors++;
                if (got !== exp_o) begin errors++; $display("FAIL cen_pixel: got %h required %h", got, exp_o); end
                held = got;
            end else begin
                vectors++; if (got !== held) begin errors++; $display("FAIL cen_hold: got %h required %h", got, held); end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit hit_a = 0, hit_b = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_h == 40 && m_v == 25) break;
            tick(1'b1);
            if (sb.size() == 0) begin vectors++; errors++; $display("FAIL sb_empty: got no entry required one"); continue; end
            exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin errors++; $display("FAIL pre_reset_pixel: got %h required %h", got, exp_o); end
        end
        rst_i = 1'b1;
        tick(1'b1);
        tick(1'b1);
        vectors++; if (vh_blank_o !== 2'b11 || dvh_sync_o !== 3'b000 || sof_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got blank=%b sync=%b sof=%b required 11 000 0", vh_blank_o, dvh_sync_o, sof_o); end
        vectors++; if (pix_x_o !== 12'd0 || pix_y_o !== 12'd0 || frame_cnt_o !== 8'd0 || vid_rgb_o !== 24'h0) begin errors++; $display("FAIL mid_rst_data: got x=%0d y=%0d fc=%0d rgb=%h required zeros", pix_x_o, pix_y_o, frame_cnt_o, vid_rgb_o); end
        rst_i = 1'b0;
        pat_sel_i = 2'd3;
        tick(1'b1);
        if (sb.size() == 0) begin vectors++; errors++; $display("FAIL sb_empty: got no entry required one"); end
        else begin exp_o = sb.pop_front(); vectors++; if (got !== exp_o) begin errors++; $display("FAIL restart_pixel: got %h required %h", got, exp_o); end end
        vectors++; if (sof_o !== 1'b1 || pix_x_o !== 12'd0 || pix_y_o !== 12'd0 || frame_cnt_o !== 8'd1) begin errors++; $display("FAIL restart_sof: got sof=%b (%0d,%0d) fc=%0d required 1 (0,0) 1", sof_o, pix_x_o, pix_y_o, frame_cnt_o); end
        for (int i = 0; i < FRAME + HT; i++) begin
            tick(1'b1);
            if (sb.size() == 0) begin vectors++; errors++; $display("FAIL sb_empty: got no entry required one"); continue; end
            exp_o = sb.pop_front(); vectors++;
            if (got !== exp_o) begin errors++; $display("FAIL checker_pixel: got %h required %h", got, exp_o); end
            if (exp_o.y == 0 && exp_o.x == 30 && exp_o.fc == 8'd1) begin
                hit_a = 1;
                vectors++; if (vid_rgb_o !== 24'h000000) begin errors++; $display("FAIL checker_f1: got %h required 000000", vid_rgb_o); end
            end
            if (exp_o.y == 0 && exp_o.x == 30 && exp_o.fc == 8'd2) begin
                hit_b = 1;
                vectors++; if (vid_rgb_o !== 24'hFFFFFF) begin errors++; $display("FAIL checker_f2: got %h required FFFFFF", vid_rgb_o); end
            end
            if (exp_o.y == 0 && exp_o.x == 31 && exp_o.fc == 8'd1) begin
                vectors++; if (vid_rgb_o !== 24'hFFFFFF) begin errors++; $display("FAIL checker_31: got %h required FFFFFF", vid_rgb_o); end
            end
        end
        vectors++; if (!(hit_a && hit_b)) begin errors++; $display("FAIL checker_frames: got hits %b%b required 11", hit_a, hit_b); end
    endtask

    task automatic test_frame_wrap();
        int nsof = 0, last = 0;
        cen_i = 1'b0;
        s_rst = 1'b1; s_cen = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        for (int i = 0; i < 255 * SFRAME + 5; i++) begin
            @(posedge clk); #1;
            if (s_sof) begin
                nsof++;
                vectors++; if (s_fc !== 8'(nsof)) begin errors++; $display("FAIL wrap_fc sof#%0d: got %0d required %0d", nsof, s_fc, nsof % 256); end
                if (nsof > 1) begin
                    vectors++; if (i - last != SFRAME) begin errors++; $display("FAIL wrap_period: got %0d required %0d", i - last, SFRAME); end
                end
                last = i;
            end
        end
        vectors++; if (nsof != 256 || s_fc !== 8'd0) begin errors++; $display("FAIL wrap_total: got %0d frames fc=%0d required 256 frames fc=0", nsof, s_fc); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_line_timing();
        test_pattern_switch();
        test_cen();
        test_mid_reset();
        test_frame_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Free-running 1080p video timing and test-pattern source that drives the video processing stage directly downstream with pixel data, blanking and sync.
- vid_rgb_o feeds the downstream vid_rgb_i, vh_blank_o feeds vh_blank_i, and dvh_sync_o feeds dvh_sync_i.
- Also exports the pixel coordinates and a start-of-frame pulse, so downstream overlays need not rebuild position from blanking edges.
- All state advances only on cycles where cen_i is high.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, horizontal sync width (pixels)
- H_BP, 148, horizontal back porch (pixels); line total = 2200
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 36, vertical back porch (lines); frame total = 1125
- SYNC_POL, 1, level of Hsync/Vsync when asserted

Ports:
- clk_i  in  1  pixel clock; one clock domain. Reset is synchronous, active-high (rst_i).
- rst_i  in  1  synchronous active-high reset
- cen_i  in  1  video clock enable
- pat_sel_i  in  2  test pattern select
- vid_rgb_o  out  24  R[23:16], G[15:8], B[7:0]
- vh_blank_o  out  2  {Vblank, Hblank}
- dvh_sync_o  out  3  {D_sync (data enable), Vsync, Hsync}
- pix_x_o  out  12  column of the current output pixel
- pix_y_o  out  12  line of the current output pixel
- sof_o  out  1  start of frame, high with pixel (0,0)
- frame_cnt_o  out  8  frame counter

Behaviour:
Counters
- h_cnt runs 0..2199. v_cnt runs 0..1124.
- On a cen_i cycle with h_cnt = 2199: h_cnt wraps to 0 and v_cnt increments.
- v_cnt wraps 1124 -> 0 on the same cycle that h_cnt wraps.
- cen_i low: all counters, registers and outputs hold their values.

Output stage
- Outputs are registered from the counter values on the same cen_i cycle that the counters advance. Outputs therefore describe position (h_cnt, v_cnt) from before the edge.
- Latency from counter to output: exactly one enabled cycle.
- pix_x_o/pix_y_o equal the registered h_cnt/v_cnt.

Timing decode (x = h_cnt, y = v_cnt)
- Hblank = x >= H_ACTIVE.
- Vblank = y >= V_ACTIVE.
- D_sync = ~Hblank & ~Vblank.
- Hsync = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (2008..2051), otherwise ~SYNC_POL.
- Vsync = SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (lines 1084..1088, whole lines), otherwise ~SYNC_POL.
- sof_o is high for exactly one enabled cycle, when the output pixel is (0,0).
- frame_cnt_o increments (mod 256) on the same edge that sof_o rises.

Pattern
- pat_sel_i is latched into pat_q only when the counters are at (0,0) on a cen_i cycle. Changes mid-frame take effect at the next frame.
- vid_rgb_o = 0 whenever D_sync = 0.
- pat 0: 8 colour bars, each 240 px wide: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- pat 1: grey ramp, R=G=B = x[10:3] (0..239).
- pat 2: solid FF_5A_43.
- pat 3: 32x32 checkerboard scrolling one pixel per frame. Pixel is white (FFFFFF) when ((x + frame_cnt) [5] ^ y[5]) = 1, else black.

Reset (rst_i high at a clock edge, wins over cen_i)
- h_cnt = 0, v_cnt = 0, pat_q = 0, frame_cnt_o = 0.
- vid_rgb_o = 0, vh_blank_o = 2'b11, dvh_sync_o = {0, ~SYNC_POL, ~SYNC_POL}.
- pix_x_o = 0, pix_y_o = 0, sof_o = 0.
- After reset releases, the first cen_i cycle outputs pixel (0,0) with sof_o = 1 and frame_cnt_o = 1.
- Reset mid-frame aborts the frame immediately; no partial sync pulse is held.

Test Plan:
- Reset values: assert rst_i for 3 cycles with cen_i = 1 -> outputs equal the reset values above. First enabled cycle after release -> sof_o = 1, pix = (0,0), vh_blank_o = 00, D_sync = 1, frame_cnt_o = 1.
- Line timing, cen_i = 1 continuous, pat 0:
  - D_sync high for exactly 1920 cycles per line.
  - Hsync = 1 on x = 2008..2051 (44 cycles).
  - Line period = 2200 cycles.
  - vid_rgb_o = FFFF00 at x = 240, 000000 at x = 1919.
- Frame timing:
  - Vblank rises at y = 1080.
  - Vsync high on lines 1084..1088.
  - sof_o period = 2,475,000 enabled cycles.
  - frame_cnt_o wraps 255 -> 0 after 256 frames (run with reduced parameters).
- Pattern switch: change pat_sel_i 0 -> 2 at pixel (100,500) -> remainder of the frame stays bars. Next frame pixel (0,0) = FF5A43. Blanking pixels remain 0.
- Clock enable: toggle cen_i 1-of-3 cycles -> all output sequences identical to the continuous run, with each value held for 3 clocks.
- Reset mid-frame at (1000,600) -> next enabled cycle after release outputs (0,0) with sof_o = 1 and frame_cnt_o = 1. Pat 3 at frame_cnt 0 vs 1: pixel (31,0) is black then white.
